// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package   : cpu_pkg
// Purpose   : Opcodes, instruction field layout and sequencer states of the 8-bit accumulator CPU.
// Revision  : 1.0
// ============================================================================
package cpu_pkg;

    localparam int CPU_DATA_WIDTH   = 8;
    localparam int CPU_ADDR_WIDTH   = 5;
    localparam int CPU_OPCODE_WIDTH = 3;

    localparam int OPCODE_MSB  = CPU_DATA_WIDTH - 1;
    localparam int OPCODE_LSB  = CPU_DATA_WIDTH - CPU_OPCODE_WIDTH;
    localparam int OPERAND_MSB = CPU_ADDR_WIDTH - 1;
    localparam int OPERAND_LSB = 0;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_JMP = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_SKZ = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_UPDATE  = 3'd4,
        S_HALT    = 3'd5,
        S_PAUSE   = 3'd6
    } seq_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/pc_next_calc.sv
`default_nettype none
// ============================================================================
// Module    : pc_next_calc
// Purpose   : Next-PC selection: jump target, skip (+2) or increment, wrapping.
// Revision  : 1.0
// ============================================================================
module pc_next_calc #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] operand_addr,
    input  logic                  jump,
    input  logic                  skip,
    input  logic                  acc_zero,
    output logic [ADDR_WIDTH-1:0] next_pc
);

    // Jump has priority over skip; sums wrap naturally at ADDR_WIDTH bits.
    always_comb begin
        next_pc = pc + ADDR_WIDTH'(1);
        if (jump) begin
            next_pc = operand_addr;
        end else if (skip && acc_zero) begin
            next_pc = pc + ADDR_WIDTH'(2);
        end
    end

endmodule : pc_next_calc
`default_nettype wire

// File: rtl/instr_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module    : instr_fetch_sequencer
// Purpose   : Fetch/decode/execute/update sequencer owning PC, IR and halt.
//             INSTR_FETCH_SINGLE_STEP_EN adds a step input and PAUSE state.
// Revision  : 1.0
// ============================================================================
module instr_fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 5,
    parameter int OPCODE_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ready,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [ADDR_WIDTH-1:0]   operand_addr,
    output logic                    instr_valid,
    input  logic                    exec_done,
    input  logic                    jump,
    input  logic                    skip,
    input  logic                    acc_zero,
    input  logic                    resume,
`ifdef INSTR_FETCH_SINGLE_STEP_EN
    input  logic                    step,
`endif
    output logic [ADDR_WIDTH-1:0]   pc,
    output logic                    halted
);

    seq_state_t            r_state;
    logic                  r_jump;
    logic                  r_skip;
    logic                  r_acc_zero;
    logic                  w_calc_jump;
    logic                  w_calc_skip;
    logic [ADDR_WIDTH-1:0] w_next_pc;

    // Outside UPDATE the calculator degenerates to pc+1, which is what HALT
    // resume needs; stale flags from the last instruction must not leak in.
    assign w_calc_jump = r_jump && (r_state == S_UPDATE);
    assign w_calc_skip = r_skip && (r_state == S_UPDATE);

    pc_next_calc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pc_next_calc (
        .pc           (pc),
        .operand_addr (operand_addr),
        .jump         (w_calc_jump),
        .skip         (w_calc_skip),
        .acc_zero     (r_acc_zero),
        .next_pc      (w_next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            pc           <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            opcode       <= '0;
            operand_addr <= '0;
            instr_valid  <= 1'b0;
            halted       <= 1'b0;
            r_jump       <= 1'b0;
            r_skip       <= 1'b0;
            r_acc_zero   <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    mem_req  <= 1'b1;
                    mem_addr <= pc;
                    r_state  <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        opcode       <= mem_rdata[DATA_WIDTH-1 -: OPCODE_WIDTH];
                        operand_addr <= mem_rdata[ADDR_WIDTH-1:0];
                        mem_req      <= 1'b0;
                        instr_valid  <= 1'b1;
                        r_state      <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (opcode == OPCODE_WIDTH'(OP_HLT)) begin
                        halted  <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (exec_done) begin
                        r_jump     <= jump;
                        r_skip     <= skip;
                        r_acc_zero <= acc_zero;
                        r_state    <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    pc <= w_next_pc;
`ifdef INSTR_FETCH_SINGLE_STEP_EN
                    r_state <= S_PAUSE;
`else
                    mem_req  <= 1'b1;
                    mem_addr <= w_next_pc;
                    r_state  <= S_FETCH;
`endif
                end
                S_HALT: begin
                    if (resume) begin
                        halted   <= 1'b0;
                        pc       <= w_next_pc;
                        mem_req  <= 1'b1;
                        mem_addr <= w_next_pc;
                        r_state  <= S_FETCH;
                    end
                end
`ifdef INSTR_FETCH_SINGLE_STEP_EN
                S_PAUSE: begin
                    if (step) begin
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                        r_state  <= S_FETCH;
                    end
                end
`endif
                default: begin
                    mem_req <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : instr_fetch_sequencer
`default_nettype wire

// File: tb/tb_instr_fetch_sequencer.sv
`default_nettype none
// Testbench for instr_fetch_sequencer: directed table, multi-cycle corner
// sequences and randomized instructions checked against a next-PC model.
module tb_instr_fetch_sequencer;

    logic       clk;
    logic       rst_n;
    logic       mem_req;
    logic [4:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic [2:0] opcode;
    logic [4:0] operand_addr;
    logic       instr_valid;
    logic       exec_done;
    logic       jump;
    logic       skip;
    logic       acc_zero;
    logic       resume;
    logic       step;
    logic [4:0] pc;
    logic       halted;

    int checks    = 0;
    int errors    = 0;
    int model_pc  = 0;
    int exp_valid = 0;
    int valid_cnt = 0;

    instr_fetch_sequencer #(
        .DATA_WIDTH   (8),
        .ADDR_WIDTH   (5),
        .OPCODE_WIDTH (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .opcode       (opcode),
        .operand_addr (operand_addr),
        .instr_valid  (instr_valid),
        .exec_done    (exec_done),
        .jump         (jump),
        .skip         (skip),
        .acc_zero     (acc_zero),
        .resume       (resume),
`ifdef INSTR_FETCH_SINGLE_STEP_EN
        .step         (step),
`endif
        .pc           (pc),
        .halted       (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (instr_valid === 1'b1) valid_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        int         start;
        logic [7:0] word;
        bit         j;
        bit         s;
        bit         az;
        int         waits;
        logic [2:0] eop;
        logic [4:0] eopnd;
        logic [4:0] enext;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Next fetch address from the architectural rules, in plain integer arithmetic.
    function automatic int ref_next(input int cur, input logic [7:0] word, input bit j, input bit s, input bit az);
        if (word[7:5] == 3'b000) return (cur + 1) % 32;
        if (j)                   return int'(word[4:0]);
        if (s && az)             return (cur + 2) % 32;
        return (cur + 1) % 32;
    endfunction

    task automatic wait_fetch();
        for (int i = 0; i < 20 && mem_req !== 1'b1; i++) @(negedge clk);
        check("fetch_req", mem_req, 1);
    endtask

    task automatic exec_one(input logic [7:0] word, input bit j, input bit s, input bit az,
                            input int waits, input int edly,
                            input logic [2:0] eop, input logic [4:0] eopnd, input logic [4:0] enext);
        logic [4:0] addr0;
        wait_fetch();
        check("fetch_addr", mem_addr, model_pc);
        check("pc_at_fetch", pc, model_pc);
        addr0 = mem_addr;
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            mem_rdata = 8'($urandom);
            @(negedge clk);
            check("wait_hold", {instr_valid, mem_req, mem_addr}, {1'b0, 1'b1, addr0});
        end
        mem_ready = 1'b1;
        mem_rdata = word;
        exec_done = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = 8'($urandom);
        exec_done = 1'b0;
        exp_valid++;
        check("decode_valid", instr_valid, 1);
        check("opcode", opcode, eop);
        check("operand", operand_addr, eopnd);
        check("decode_req", mem_req, 0);
        if (eop == 3'b000) begin
            @(negedge clk);
            check("halted", halted, 1);
            check("halt_pc", pc, model_pc);
            for (int i = 0; i < 10; i++) begin
                exec_done = 1'b1;
                jump      = 1'b1;
                skip      = 1'b1;
                acc_zero  = 1'b1;
                @(negedge clk);
                check("halt_hold", {mem_req, halted, pc}, {1'b0, 1'b1, 5'(model_pc)});
            end
            exec_done = 1'b0;
            jump      = 1'b0;
            skip      = 1'b0;
            acc_zero  = 1'b0;
            resume    = 1'b1;
            @(negedge clk);
            resume = 1'b0;
            check("resume", {halted, mem_req, pc}, {1'b0, 1'b1, enext});
        end else begin
            @(negedge clk);
            check("exec_valid_low", {instr_valid, mem_req}, 2'b00);
            for (int i = 0; i < edly; i++) begin
                jump     = ~j;
                skip     = ~s;
                acc_zero = ~az;
                @(negedge clk);
            end
            exec_done = 1'b1;
            jump      = j;
            skip      = s;
            acc_zero  = az;
            @(negedge clk);
            exec_done = 1'b0;
            jump      = ~j;
            skip      = ~s;
            acc_zero  = ~az;
            @(negedge clk);
            jump     = 1'b0;
            skip     = 1'b0;
            acc_zero = 1'b0;
            check("next_pc", pc, enext);
`ifdef INSTR_FETCH_SINGLE_STEP_EN
            for (int i = 0; i < 3; i++) begin
                check("pause_req", mem_req, 0);
                @(negedge clk);
            end
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            check("step_fetch", {mem_req, mem_addr}, {1'b1, enext});
`endif
        end
        model_pc = int'(enext);
        check("valid_count", valid_cnt, exp_valid);
    endtask

    initial begin
        logic [7:0] w;
        bit         rj, rs, raz;

        vecs[0]  = '{0,  8'h40, 0, 0, 0, 0, 3'b010, 5'd0,  5'd1};
        vecs[1]  = '{1,  8'h61, 0, 0, 0, 0, 3'b011, 5'd1,  5'd2};
        vecs[2]  = '{2,  8'h3A, 1, 0, 0, 0, 3'b001, 5'd26, 5'd26};
        vecs[3]  = '{30, 8'hE0, 0, 1, 1, 0, 3'b111, 5'd0,  5'd0};
        vecs[4]  = '{30, 8'hE0, 0, 1, 0, 0, 3'b111, 5'd0,  5'd31};
        vecs[5]  = '{31, 8'hE5, 0, 1, 1, 1, 3'b111, 5'd5,  5'd1};
        vecs[6]  = '{31, 8'hA3, 0, 0, 0, 0, 3'b101, 5'd3,  5'd0};
        vecs[7]  = '{4,  8'h2C, 1, 1, 1, 0, 3'b001, 5'd12, 5'd12};
        vecs[8]  = '{7,  8'h00, 0, 0, 0, 3, 3'b000, 5'd0,  5'd8};
        vecs[9]  = '{10, 8'hC9, 0, 0, 1, 2, 3'b110, 5'd9,  5'd11};
        vecs[10] = '{20, 8'h9F, 1, 0, 0, 0, 3'b100, 5'd31, 5'd31};

        rst_n     = 1'b0;
        mem_rdata = 8'h00;
        mem_ready = 1'b0;
        exec_done = 1'b0;
        jump      = 1'b0;
        skip      = 1'b0;
        acc_zero  = 1'b0;
        resume    = 1'b0;
        step      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {mem_req, mem_addr, opcode, operand_addr, instr_valid, pc, halted}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_then_fetch", {mem_req, mem_addr}, {1'b1, 5'd0});

        // Asynchronous reset while a fetch at pc=5 is outstanding.
        exec_one(8'h25, 1, 0, 0, 0, 0, 3'b001, 5'd5, 5'd5);
        check("pre_reset_req", {mem_req, mem_addr}, {1'b1, 5'd5});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {mem_req, mem_addr, pc, instr_valid, halted}, '0);
        @(negedge clk);
        rst_n    = 1'b1;
        model_pc = 0;

        foreach (vecs[k]) begin
            if (model_pc != vecs[k].start)
                exec_one({3'b001, 5'(vecs[k].start)}, 1, 0, 0, 0, 0, 3'b001,
                         5'(vecs[k].start), 5'(vecs[k].start));
            exec_one(vecs[k].word, vecs[k].j, vecs[k].s, vecs[k].az, vecs[k].waits, 0,
                     vecs[k].eop, vecs[k].eopnd, vecs[k].enext);
        end

        for (int n = 0; n < 40; n++) begin
            w = 8'($urandom);
            if ($urandom_range(0, 7) == 0) w[7:5] = 3'b000;
            else if (w[7:5] == 3'b000)     w[7:5] = 3'b010;
            rj  = 1'($urandom_range(0, 1));
            rs  = 1'($urandom_range(0, 1));
            raz = 1'($urandom_range(0, 1));
            exec_one(w, rj, rs, raz, $urandom_range(0, 2), $urandom_range(0, 2),
                     w[7:5], w[4:0], 5'(ref_next(model_pc, w, rj, rs, raz)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instr_fetch_sequencer
`default_nettype wire
